// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 key decode merged with MiSTer joysticks, coin stretching
// and an auto-coin-on-start sequencer. Define INPUT_AUTOFIRE_EN to build fire0 autofire.
module arcade_input_mapper #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 1,
  parameter int COIN_CYCLES  = 600000,
  parameter int GAP_CYCLES   = 600000,
  parameter int AUTOFIRE_DIV = 200000
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joy_in,
  input  logic                       auto_coin,
  input  logic [PLAYERS-1:0]         autofire,
  output logic [4*PLAYERS-1:0]       dir_out,
  output logic [BUTTONS*PLAYERS-1:0] fire_out,
  output logic [PLAYERS-1:0]         start_out,
  output logic [1:0]                 coin_out
);

  localparam int MAX_CG  = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_CG > AUTOFIRE_DIV) ? MAX_CG : AUTOFIRE_DIV;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam int PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam int NKEYS = 17;
  localparam int K_P0_UP = 0, K_P0_DOWN = 1, K_P0_LEFT = 2, K_P0_RIGHT = 3;
  localparam int K_P0_FIRE_A = 4, K_P0_FIRE_B = 5;
  localparam int K_P1_UP = 6, K_P1_DOWN = 7, K_P1_LEFT = 8, K_P1_RIGHT = 9, K_P1_FIRE = 10;
  localparam int K_START0_A = 11, K_START0_B = 12, K_START1_A = 13, K_START1_B = 14;
  localparam int K_COIN1 = 15, K_COIN2 = 16;

  typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_START} state_t;

  // ---------------- PS/2 event decode ----------------
  logic             tog_q, primed_q, key_event;
  logic [NKEYS-1:0] key_match, key_q, key_d;

  // primed_q keeps the first post-reset cycle from seeing a stale toggle
  assign key_event = primed_q && (ps2_key[10] != tog_q);

  always_comb begin
    key_match = '0;
    case (ps2_key[7:0])
      8'h75:   key_match[K_P0_UP]     = 1'b1;
      8'h72:   key_match[K_P0_DOWN]   = 1'b1;
      8'h6B:   key_match[K_P0_LEFT]   = 1'b1;
      8'h74:   key_match[K_P0_RIGHT]  = 1'b1;
      8'h29:   key_match[K_P0_FIRE_A] = 1'b1;
      8'h14:   key_match[K_P0_FIRE_B] = ~ps2_key[8];
      8'h1D:   key_match[K_P1_UP]     = 1'b1;
      8'h1B:   key_match[K_P1_DOWN]   = 1'b1;
      8'h1C:   key_match[K_P1_LEFT]   = 1'b1;
      8'h23:   key_match[K_P1_RIGHT]  = 1'b1;
      8'h12:   key_match[K_P1_FIRE]   = ~ps2_key[8];
      8'h16:   key_match[K_START0_A]  = 1'b1;
      8'h05:   key_match[K_START0_B]  = 1'b1;
      8'h1E:   key_match[K_START1_A]  = 1'b1;
      8'h06:   key_match[K_START1_B]  = 1'b1;
      8'h2E:   key_match[K_COIN1]     = 1'b1;
      8'h36:   key_match[K_COIN2]     = 1'b1;
      default: key_match = '0;
    endcase
  end

  always_comb begin
    key_d = key_q;
    if (key_event) begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (key_match[i]) key_d[i] = ps2_key[9];
      end
    end
  end

  // ---------------- keyboard / joystick merge ----------------
  logic [4*PLAYERS-1:0]       raw_dir;
  logic [BUTTONS*PLAYERS-1:0] raw_fire;
  logic [PLAYERS-1:0]         raw_start;
  logic [1:0]                 raw_coin;
  logic [3:0]                 kdir;
  logic                       kfire, kstart;

  always_comb begin
    raw_dir   = '0;
    raw_fire  = '0;
    raw_start = '0;
    raw_coin  = {key_q[K_COIN2], key_q[K_COIN1]};
    kdir      = '0;
    kfire     = 1'b0;
    kstart    = 1'b0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      kdir   = '0;
      kfire  = 1'b0;
      kstart = 1'b0;
      if (p == 0) begin
        kdir   = {key_q[K_P0_UP], key_q[K_P0_DOWN], key_q[K_P0_LEFT], key_q[K_P0_RIGHT]};
        kfire  = key_q[K_P0_FIRE_A] | key_q[K_P0_FIRE_B];
        kstart = key_q[K_START0_A] | key_q[K_START0_B];
      end else if (p == 1) begin
        kdir   = {key_q[K_P1_UP], key_q[K_P1_DOWN], key_q[K_P1_LEFT], key_q[K_P1_RIGHT]};
        kfire  = key_q[K_P1_FIRE];
        kstart = key_q[K_START1_A] | key_q[K_START1_B];
      end
      raw_dir[4*p +: 4]              = joy_in[16*p +: 4] | kdir;
      raw_fire[BUTTONS*p +: BUTTONS] = joy_in[16*p+4 +: BUTTONS];
      raw_fire[BUTTONS*p]            = joy_in[16*p+4] | kfire;
      raw_start[p]                   = joy_in[16*p+4+BUTTONS] | kstart;
      raw_coin[0]                    = raw_coin[0] | joy_in[16*p+5+BUTTONS];
    end
  end

  // ---------------- auto-coin sequencer ----------------
  state_t             state_q, state_d;
  logic [CW-1:0]      seq_cnt_q, seq_cnt_d;
  logic [PW-1:0]      sel_q, sel_d, sel_lo;
  logic [PLAYERS-1:0] start_raw_q, start_edge, fsm_start, start_d;
  logic               fsm_coin, found;

  always_comb begin
    start_edge = raw_start & ~start_raw_q;
    sel_lo     = '0;
    found      = 1'b0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (start_edge[p] && !found) begin
        sel_lo = PW'(p);
        found  = 1'b1;
      end
    end

    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    sel_d     = sel_q;
    if (!auto_coin) begin
      state_d   = S_IDLE;
      seq_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (found) begin
          state_d   = S_COIN;
          seq_cnt_d = COIN_LOAD;
          sel_d     = sel_lo;
        end
        S_COIN: if (seq_cnt_q == '0) begin
          state_d   = S_GAP;
          seq_cnt_d = GAP_LOAD;
        end else seq_cnt_d = seq_cnt_q - ONE;
        S_GAP: if (seq_cnt_q == '0) begin
          state_d   = S_START;
          seq_cnt_d = COIN_LOAD;
        end else seq_cnt_d = seq_cnt_q - ONE;
        S_START: if (seq_cnt_q == '0) state_d = S_IDLE;
                 else seq_cnt_d = seq_cnt_q - ONE;
        default: state_d = S_IDLE;
      endcase
    end

    // outputs gated by auto_coin so dropping it releases them the same cycle
    fsm_coin  = auto_coin && (state_q == S_COIN);
    fsm_start = '0;
    if (auto_coin && (state_q == S_START)) fsm_start[sel_q] = 1'b1;
    start_d = auto_coin ? fsm_start : raw_start;
  end

  // ---------------- coin stretch ----------------
  logic [1:0]         coin_raw_q, coin_d;
  logic [1:0][CW-1:0] coin_cnt_q, coin_cnt_d;

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (raw_coin[s] && !coin_raw_q[s]) coin_cnt_d[s] = COIN_LOAD;
      else if (coin_cnt_q[s] != '0)      coin_cnt_d[s] = coin_cnt_q[s] - ONE;
      else                               coin_cnt_d[s] = '0;
    end
    coin_d[0] = raw_coin[0] | (coin_cnt_q[0] != '0) | fsm_coin;
    coin_d[1] = raw_coin[1] | (coin_cnt_q[1] != '0);
  end

  // ---------------- fire / autofire ----------------
  logic [BUTTONS*PLAYERS-1:0] fire_d;

`ifdef INPUT_AUTOFIRE_EN
  logic [PLAYERS-1:0]         af_raw_q, af_phase_q, af_phase_d;
  logic [PLAYERS-1:0][CW-1:0] af_cnt_q, af_cnt_d;
  localparam logic [CW-1:0]   AF_LOAD = CW'(AUTOFIRE_DIV - 1);

  always_comb begin
    fire_d     = raw_fire;
    af_phase_d = '0;
    af_cnt_d   = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (autofire[p] && raw_fire[BUTTONS*p]) begin
        if (!af_raw_q[p]) begin
          af_phase_d[p] = 1'b1;
          af_cnt_d[p]   = AF_LOAD;
        end else if (af_cnt_q[p] == '0) begin
          af_phase_d[p] = ~af_phase_q[p];
          af_cnt_d[p]   = AF_LOAD;
        end else begin
          af_phase_d[p] = af_phase_q[p];
          af_cnt_d[p]   = af_cnt_q[p] - ONE;
        end
        fire_d[BUTTONS*p] = af_phase_d[p];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_raw_q   <= '0;
      af_phase_q <= '0;
      af_cnt_q   <= '0;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) af_raw_q[p] <= raw_fire[BUTTONS*p];
      af_phase_q <= af_phase_d;
      af_cnt_q   <= af_cnt_d;
    end
  end
`else
  assign fire_d = raw_fire;
`endif

  // ---------------- registers ----------------
  logic [4*PLAYERS-1:0]       dir_q;
  logic [BUTTONS*PLAYERS-1:0] fire_q;
  logic [PLAYERS-1:0]         start_q;
  logic [1:0]                 coin_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q       <= 1'b0;
      primed_q    <= 1'b0;
      key_q       <= '0;
      dir_q       <= '0;
      fire_q      <= '0;
      start_q     <= '0;
      coin_q      <= '0;
      coin_raw_q  <= '0;
      coin_cnt_q  <= '0;
      start_raw_q <= '0;
      state_q     <= S_IDLE;
      seq_cnt_q   <= '0;
      sel_q       <= '0;
    end else begin
      tog_q       <= ps2_key[10];
      primed_q    <= 1'b1;
      key_q       <= key_d;
      dir_q       <= raw_dir;
      fire_q      <= fire_d;
      start_q     <= start_d;
      coin_q      <= coin_d;
      coin_raw_q  <= raw_coin;
      coin_cnt_q  <= coin_cnt_d;
      start_raw_q <= raw_start;
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      sel_q       <= sel_d;
    end
  end

  assign dir_out   = dir_q;
  assign fire_out  = fire_q;
  assign start_out = start_q;
  assign coin_out  = coin_q;

  // spare joystick bits (and autofire when not built) are intentionally unused
  logic unused_inputs;
  assign unused_inputs = ^{joy_in, autofire};

endmodule
